network_queue_link_ctrl: RTL and testbench
==========================================

// Module: network_queue_link_ctrl
// PURPOSE
// - Linked-list queue controller between network_input_queue and network_queue_manage.
// - Keeps a head pointer, tail pointer and depth for each of QUEUE_NUM priority queues of 9-bit packet buffer IDs.
// - Enqueue links a new ID behind the tail by writing the 512x9 link RAM, where link RAM[id] = next id.
// - Dequeue pops the head; the new head comes from a link-RAM read through network_queue_manage.
// PARAMETERS
// - QUEUE_NUM  8   number of priority queues; queue ID width is clog2(QUEUE_NUM) = 3
// - ID_W       9   packet buffer ID width; link RAM depth is 2^ID_W = 512
// - CNT_W      10  per-queue depth counter width; holds 0..512
// PORTS
// - i_clk                 in   1   125 MHz clock
// - i_rst_n               in   1   asynchronous active-low reset
// - i_enq_wr              in   1   enqueue strobe, one cycle per ID
// - iv_enq_pkt_id         in   9   buffer ID to enqueue
// - iv_enq_queue_id       in   3   target queue
// - i_deq_req             in   1   dequeue request pulse from output schedule
// - iv_deq_queue_id       in   3   queue to pop
// - ov_deq_pkt_id         out  9   popped buffer ID
// - o_deq_pkt_id_valid    out  1   one-cycle pulse qualifying ov_deq_pkt_id
// - o_deq_busy            out  1   dequeue in progress; i_deq_req is ignored while high
// - ov_queue_empty        out  8   bit q high when depth[q] == 0
// - ov_queue_waddr        out  9   link RAM write address (old tail)
// - ov_queue_wdata        out  9   link RAM write data (new ID)
// - o_queue_wr            out  1   link RAM write strobe
// - ov_queue_raddr        out  9   link RAM read address (head)
// - o_queue_rd            out  1   link RAM read strobe, one-cycle pulse
// - iv_queue_rdata        in   9   next pointer returned by queue manage
// - i_queue_rdata_valid   in   1   qualifies iv_queue_rdata
// BEHAVIOUR
// Reset
// - All outputs 0, except ov_queue_empty = 8'hFF.
// - All heads, tails and depths 0. FSM goes to IDLE_S.
// - Reset mid-read abandons the read; a late i_queue_rdata_valid seen in IDLE_S is ignored.
// Enqueue (always accepted, single cycle)
// - Depth 0: head = tail = id, depth = 1, no RAM write.
// - Otherwise: one-cycle o_queue_wr with waddr = tail, wdata = id; then tail = id, depth + 1.
// - Depth never exceeds 512 because IDs are unique. Overflow behaviour is undefined and is not checked.
// Dequeue FSM
// - IDLE_S, on i_deq_req:
//   - Depth 0: request dropped; no valid pulse, busy stays 0.
//   - Depth 1: ov_deq_pkt_id = head, valid next cycle, depth = 0; go to IDLE_S. No RAM read.
//   - Depth > 1: o_queue_rd = 1 with raddr = head, latch queue ID, busy = 1; go to RD_WAIT_S.
// - RD_WAIT_S:
//   - Hold ov_queue_raddr stable; queue manage compares it against the write address for bypass.
//   - Wait for i_queue_rdata_valid, which arrives 2 to 4 cycles after o_queue_rd.
//   - On valid: ov_deq_pkt_id = old head, valid pulse, head = iv_queue_rdata, depth - 1, busy = 0; go to IDLE_S.
// - Throughput: one dequeue at a time. The next i_deq_req is accepted in the cycle after busy falls.
// Simultaneous events
// - Enqueue and dequeue on the same queue in the same cycle, depth 1: pop the old head; new head = tail = enq id, depth stays 1, no RAM write.
// - Enqueue and dequeue on the same queue, depth 0: dequeue dropped; enqueue proceeds as a depth-0 enqueue.
// - Enqueue during RD_WAIT_S to the queue being popped: tail and depth + 1 update normally. The head is not touched until read data returns.
// - Same-cycle depth +1 and -1 on one queue nets to 0.
// - ov_queue_empty is registered from the updated depths, so it reflects a change one cycle after the enqueue or dequeue.
// CONFIGURATION
// - NQLC_DEPTH_OUT_EN defined: adds output ov_queue_depth (8 x 10 = 80 bits, queue q at bits [10q+9:10q]) carrying the registered depths.
// - NQLC_DEPTH_OUT_EN undefined: the port is absent. All other behaviour is identical.
// TESTING
// 1. Reset, then deq q0 -> no valid pulse, busy stays 0, ov_queue_empty = 8'hFF.
// 2. Enq id 5 then id 9 to q2 -> o_queue_wr once with waddr = 5, wdata = 9; ov_queue_empty[2] = 0.
// 3. Continue from 2: deq q2 -> o_queue_rd with raddr = 5; on rdata valid (value 9), deq id 5 pulses and head = 9.
//    Deq q2 again -> id 9 pops with no RAM read; empty[2] = 1.
// 4. Enq ids 1, 2, 3 to q7, then deq q7 while enq id 4 to q7 lands during RD_WAIT_S
//    -> pops come out 1, 2, 3, 4 in order; RAM write 3 -> 4 is seen.
// 5. q1 holds only id 7; deq q1 and enq id 8 to q1 in the same cycle -> id 7 pops; head = tail = 8, depth 1, no RAM write.
// 6. Assert reset while in RD_WAIT_S -> busy = 0, all queues empty; a stale rdata_valid afterwards produces no output.

Source files
------------

// File: rtl/network_queue_link_ctrl.sv
// Linked-list queue controller: per-queue head/tail/depth for QUEUE_NUM queues of buffer IDs.
// Optional macro NQLC_DEPTH_OUT_EN adds the ov_queue_depth output carrying the registered depths.
//
// state      | meaning
// IDLE_S     | no dequeue in flight; i_deq_req is accepted
// RD_WAIT_S  | link RAM read issued for the popped head; waiting for the next pointer
module network_queue_link_ctrl #(
    parameter int QUEUE_NUM = 8,
    parameter int ID_W      = 9,
    parameter int CNT_W     = 10,
    localparam int QID_W    = $clog2(QUEUE_NUM)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enq_wr,
    input  logic [ID_W-1:0]            iv_enq_pkt_id,
    input  logic [QID_W-1:0]           iv_enq_queue_id,
    input  logic                       i_deq_req,
    input  logic [QID_W-1:0]           iv_deq_queue_id,
    output logic [ID_W-1:0]            ov_deq_pkt_id,
    output logic                       o_deq_pkt_id_valid,
    output logic                       o_deq_busy,
    output logic [QUEUE_NUM-1:0]       ov_queue_empty,
`ifdef NQLC_DEPTH_OUT_EN
    output logic [QUEUE_NUM*CNT_W-1:0] ov_queue_depth,
`endif
    output logic [ID_W-1:0]            ov_queue_waddr,
    output logic [ID_W-1:0]            ov_queue_wdata,
    output logic                       o_queue_wr,
    output logic [ID_W-1:0]            ov_queue_raddr,
    output logic                       o_queue_rd,
    input  logic [ID_W-1:0]            iv_queue_rdata,
    input  logic                       i_queue_rdata_valid
);

    typedef enum logic [0:0] {
        IDLE_S    = 1'b0,
        RD_WAIT_S = 1'b1
    } state_t;

    state_t state_r, state_n;

    logic [QUEUE_NUM-1:0][ID_W-1:0]  head_r, head_n;
    logic [QUEUE_NUM-1:0][ID_W-1:0]  tail_r, tail_n;
    logic [QUEUE_NUM-1:0][CNT_W-1:0] depth_r, depth_n;
    logic [QUEUE_NUM-1:0]            empty_r, empty_n;

    logic [QID_W-1:0] deq_q_r, deq_q_n;
    logic [ID_W-1:0]  deq_id_r, deq_id_n;
    logic             deq_vld_r, deq_vld_n;
    logic             busy_r, busy_n;
    logic             rd_r, rd_n;
    logic [ID_W-1:0]  raddr_r, raddr_n;
    logic             wr_r, wr_n;
    logic [ID_W-1:0]  waddr_r, waddr_n;
    logic [ID_W-1:0]  wdata_r, wdata_n;
    logic             pop_one;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= IDLE_S;
            head_r    <= '0;
            tail_r    <= '0;
            depth_r   <= '0;
            empty_r   <= '1;
            deq_q_r   <= '0;
            deq_id_r  <= '0;
            deq_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            rd_r      <= 1'b0;
            raddr_r   <= '0;
            wr_r      <= 1'b0;
            waddr_r   <= '0;
            wdata_r   <= '0;
        end else begin
            state_r   <= state_n;
            head_r    <= head_n;
            tail_r    <= tail_n;
            depth_r   <= depth_n;
            empty_r   <= empty_n;
            deq_q_r   <= deq_q_n;
            deq_id_r  <= deq_id_n;
            deq_vld_r <= deq_vld_n;
            busy_r    <= busy_n;
            rd_r      <= rd_n;
            raddr_r   <= raddr_n;
            wr_r      <= wr_n;
            waddr_r   <= waddr_n;
            wdata_r   <= wdata_n;
        end
    end

    always_comb begin
        state_n   = state_r;
        head_n    = head_r;
        tail_n    = tail_r;
        depth_n   = depth_r;
        empty_n   = empty_r;
        deq_q_n   = deq_q_r;
        deq_id_n  = deq_id_r;
        deq_vld_n = 1'b0;
        busy_n    = busy_r;
        rd_n      = 1'b0;
        raddr_n   = raddr_r;
        wr_n      = 1'b0;
        waddr_n   = waddr_r;
        wdata_n   = wdata_r;
        pop_one   = 1'b0;

        case (state_r)
            IDLE_S: begin
                if (i_deq_req) begin
                    if (depth_r[iv_deq_queue_id] == CNT_W'(1)) begin
                        pop_one                  = 1'b1;
                        deq_id_n                 = head_r[iv_deq_queue_id];
                        deq_vld_n                = 1'b1;
                        depth_n[iv_deq_queue_id] = '0;
                    end else if (depth_r[iv_deq_queue_id] > CNT_W'(1)) begin
                        rd_n    = 1'b1;
                        raddr_n = head_r[iv_deq_queue_id];
                        deq_q_n = iv_deq_queue_id;
                        busy_n  = 1'b1;
                        state_n = RD_WAIT_S;
                    end
                end
            end
            RD_WAIT_S: begin
                // raddr_r stays put so queue manage can bypass against the pending write.
                if (i_queue_rdata_valid) begin
                    deq_id_n         = head_r[deq_q_r];
                    deq_vld_n        = 1'b1;
                    head_n[deq_q_r]  = iv_queue_rdata;
                    depth_n[deq_q_r] = depth_r[deq_q_r] - CNT_W'(1);
                    busy_n           = 1'b0;
                    state_n          = IDLE_S;
                end
            end
            default: state_n = IDLE_S;
        endcase

        // Enqueue applies after the pop so same-cycle +1/-1 on one queue nets out.
        if (i_enq_wr) begin
            if (depth_r[iv_enq_queue_id] == '0 ||
                (pop_one && iv_deq_queue_id == iv_enq_queue_id)) begin
                head_n[iv_enq_queue_id]  = iv_enq_pkt_id;
                tail_n[iv_enq_queue_id]  = iv_enq_pkt_id;
                depth_n[iv_enq_queue_id] = CNT_W'(1);
            end else begin
                wr_n                     = 1'b1;
                waddr_n                  = tail_r[iv_enq_queue_id];
                wdata_n                  = iv_enq_pkt_id;
                tail_n[iv_enq_queue_id]  = iv_enq_pkt_id;
                depth_n[iv_enq_queue_id] = depth_n[iv_enq_queue_id] + CNT_W'(1);
            end
        end

        for (int q = 0; q < QUEUE_NUM; q++) begin
            empty_n[q] = (depth_n[q] == '0);
        end
    end

    assign ov_deq_pkt_id      = deq_id_r;
    assign o_deq_pkt_id_valid = deq_vld_r;
    assign o_deq_busy         = busy_r;
    assign ov_queue_empty     = empty_r;
    assign ov_queue_waddr     = waddr_r;
    assign ov_queue_wdata     = wdata_r;
    assign o_queue_wr         = wr_r;
    assign ov_queue_raddr     = raddr_r;
    assign o_queue_rd         = rd_r;

`ifdef NQLC_DEPTH_OUT_EN
    assign ov_queue_depth = depth_r;
`endif

endmodule

// File: tb/tb_network_queue_link_ctrl.sv
// Scoreboard bench for network_queue_link_ctrl: directed enqueue/dequeue vectors with a
// responder standing in for queue manage (link RAM with 2..4 cycle read latency).
module tb_network_queue_link_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_enq_wr;
    logic [8:0] iv_enq_pkt_id;
    logic [2:0] iv_enq_queue_id;
    logic       i_deq_req;
    logic [2:0] iv_deq_queue_id;
    logic [8:0] ov_deq_pkt_id;
    logic       o_deq_pkt_id_valid;
    logic       o_deq_busy;
    logic [7:0] ov_queue_empty;
    logic [8:0] ov_queue_waddr;
    logic [8:0] ov_queue_wdata;
    logic       o_queue_wr;
    logic [8:0] ov_queue_raddr;
    logic       o_queue_rd;
    logic [8:0] iv_queue_rdata;
    logic       i_queue_rdata_valid;

    network_queue_link_ctrl dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_enq_wr            (i_enq_wr),
        .iv_enq_pkt_id       (iv_enq_pkt_id),
        .iv_enq_queue_id     (iv_enq_queue_id),
        .i_deq_req           (i_deq_req),
        .iv_deq_queue_id     (iv_deq_queue_id),
        .ov_deq_pkt_id       (ov_deq_pkt_id),
        .o_deq_pkt_id_valid  (o_deq_pkt_id_valid),
        .o_deq_busy          (o_deq_busy),
        .ov_queue_empty      (ov_queue_empty),
        .ov_queue_waddr      (ov_queue_waddr),
        .ov_queue_wdata      (ov_queue_wdata),
        .o_queue_wr          (o_queue_wr),
        .ov_queue_raddr      (ov_queue_raddr),
        .o_queue_rd          (o_queue_rd),
        .iv_queue_rdata      (iv_queue_rdata),
        .i_queue_rdata_valid (i_queue_rdata_valid)
    );

    int checks = 0;
    int errors = 0;
    int deq_cnt = 0;
    int resp_lat = 3;

    logic [8:0]  exp_deq[$];
    logic [17:0] exp_wr[$];
    logic [8:0]  exp_rd[$];
    logic [8:0]  link_mem [512];

    initial i_clk = 1'b0;
    always #4 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT output event is compared against the head of its queue.
    always @(negedge i_clk) begin
        if (o_deq_pkt_id_valid) begin
            deq_cnt++;
            if (exp_deq.size() == 0) begin
                checks++; errors++;
                $display("FAIL deq_unexpected: got id %0d expected no pop", ov_deq_pkt_id);
            end else begin
                chk("deq_id", {23'd0, ov_deq_pkt_id}, {23'd0, exp_deq.pop_front()});
            end
        end
        if (o_queue_wr) begin
            link_mem[ov_queue_waddr] = ov_queue_wdata;
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: got %0d->%0d expected no write",
                         ov_queue_waddr, ov_queue_wdata);
            end else begin
                chk("ram_wr", {14'd0, ov_queue_waddr, ov_queue_wdata}, {14'd0, exp_wr.pop_front()});
            end
        end
        if (o_queue_rd) begin
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got raddr %0d expected no read", ov_queue_raddr);
            end else begin
                chk("ram_rd", {23'd0, ov_queue_raddr}, {23'd0, exp_rd.pop_front()});
            end
        end
    end

    // Queue manage stand-in: answers each read resp_lat cycles later.
    initial begin
        logic [8:0] a;
        i_queue_rdata_valid = 1'b0;
        iv_queue_rdata      = '0;
        forever begin
            @(negedge i_clk);
            if (o_queue_rd) begin
                a = ov_queue_raddr;
                repeat (resp_lat) @(negedge i_clk);
                iv_queue_rdata      = link_mem[a];
                i_queue_rdata_valid = 1'b1;
                @(negedge i_clk);
                i_queue_rdata_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(negedge i_clk);
    endtask

    task automatic enq(input logic [2:0] q, input logic [8:0] id);
        i_enq_wr = 1'b1; iv_enq_queue_id = q; iv_enq_pkt_id = id;
        cyc();
        i_enq_wr = 1'b0;
    endtask

    task automatic deq(input logic [2:0] q);
        i_deq_req = 1'b1; iv_deq_queue_id = q;
        cyc();
        i_deq_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_deq_busy && n < 20) begin
            cyc();
            n++;
        end
        if (o_deq_busy) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
        end
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) link_mem[i] = '0;
        i_rst_n = 1'b0; i_enq_wr = 1'b0; iv_enq_pkt_id = '0; iv_enq_queue_id = '0;
        i_deq_req = 1'b0; iv_deq_queue_id = '0;
        repeat (3) cyc();
        i_rst_n = 1'b1;
        cyc();

        chk("rst_empty", {24'd0, ov_queue_empty}, 32'hFF);
        chk("rst_outs", {26'd0, o_deq_busy, o_deq_pkt_id_valid, o_queue_wr, o_queue_rd,
                         |ov_deq_pkt_id, |ov_queue_raddr}, 32'd0);

        // Dequeue of an empty queue is dropped.
        deq(3'd0);
        repeat (3) cyc();
        chk("t1_busy", {31'd0, o_deq_busy}, 32'd0);
        chk("t1_empty", {24'd0, ov_queue_empty}, 32'hFF);
        chk("t1_pops", deq_cnt, 32'd0);

        // Two enqueues link 5 -> 9.
        exp_wr.push_back({9'd5, 9'd9});
        enq(3'd2, 9'd5);
        chk("t2_empty_a", {24'd0, ov_queue_empty}, 32'hFB);
        enq(3'd2, 9'd9);
        cyc();
        chk("t2_empty_b", {24'd0, ov_queue_empty}, 32'hFB);

        // Pop through a RAM read, then a depth-1 pop without one.
        exp_rd.push_back(9'd5);
        exp_deq.push_back(9'd5);
        deq(3'd2);
        chk("t3_busy", {31'd0, o_deq_busy}, 32'd1);
        wait_idle("t3");
        exp_deq.push_back(9'd9);
        deq(3'd2);
        cyc();
        chk("t3_empty", {24'd0, ov_queue_empty}, 32'hFF);
        chk("t3_busy_lo", {31'd0, o_deq_busy}, 32'd0);

        // Enqueue of id 4 lands while the first pop of q7 waits on read data.
        exp_wr.push_back({9'd1, 9'd2});
        exp_wr.push_back({9'd2, 9'd3});
        enq(3'd7, 9'd1);
        enq(3'd7, 9'd2);
        enq(3'd7, 9'd3);
        resp_lat = 4;
        exp_rd.push_back(9'd1);
        exp_deq.push_back(9'd1);
        exp_wr.push_back({9'd3, 9'd4});
        deq(3'd7);
        enq(3'd7, 9'd4);
        wait_idle("t4a");
        resp_lat = 2;
        exp_rd.push_back(9'd2);
        exp_deq.push_back(9'd2);
        deq(3'd7);
        wait_idle("t4b");
        resp_lat = 3;
        exp_rd.push_back(9'd3);
        exp_deq.push_back(9'd3);
        deq(3'd7);
        wait_idle("t4c");
        exp_deq.push_back(9'd4);
        deq(3'd7);
        cyc();
        chk("t4_empty", {24'd0, ov_queue_empty}, 32'hFF);

        // Same-cycle dequeue and enqueue on a depth-1 queue.
        enq(3'd1, 9'd7);
        exp_deq.push_back(9'd7);
        i_deq_req = 1'b1; iv_deq_queue_id = 3'd1;
        i_enq_wr = 1'b1; iv_enq_queue_id = 3'd1; iv_enq_pkt_id = 9'd8;
        cyc();
        i_deq_req = 1'b0; i_enq_wr = 1'b0;
        cyc();
        chk("t5_empty", {24'd0, ov_queue_empty}, 32'hFD);
        exp_deq.push_back(9'd8);
        deq(3'd1);
        cyc();
        chk("t5_empty_b", {24'd0, ov_queue_empty}, 32'hFF);

        // Same-cycle dequeue and enqueue on an empty queue: dequeue dropped.
        i_deq_req = 1'b1; iv_deq_queue_id = 3'd4;
        i_enq_wr = 1'b1; iv_enq_queue_id = 3'd4; iv_enq_pkt_id = 9'd20;
        cyc();
        i_deq_req = 1'b0; i_enq_wr = 1'b0;
        cyc();
        chk("t5_drop_pops", deq_cnt, 32'd8);
        chk("t5_drop_empty", {24'd0, ov_queue_empty}, 32'hEF);
        exp_deq.push_back(9'd20);
        deq(3'd4);
        cyc();
        chk("t5_pops", deq_cnt, 32'd9);

        // Reset during RD_WAIT_S; the late read data must be ignored.
        exp_wr.push_back({9'd10, 9'd11});
        enq(3'd3, 9'd10);
        enq(3'd3, 9'd11);
        resp_lat = 4;
        exp_rd.push_back(9'd10);
        deq(3'd3);
        chk("t6_busy", {31'd0, o_deq_busy}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, o_deq_busy}, 32'd0);
        chk("t6_rst_empty", {24'd0, ov_queue_empty}, 32'hFF);
        cyc();
        i_rst_n = 1'b1;
        repeat (8) cyc();
        chk("t6_busy_after", {31'd0, o_deq_busy}, 32'd0);
        chk("t6_pops", deq_cnt, 32'd9);
        chk("t6_empty_after", {24'd0, ov_queue_empty}, 32'hFF);
        resp_lat = 3;
        enq(3'd0, 9'd30);
        exp_deq.push_back(9'd30);
        deq(3'd0);
        cyc();
        chk("t6_recover_pops", deq_cnt, 32'd10);

        repeat (4) cyc();
        chk("sb_deq_left", exp_deq.size(), 32'd0);
        chk("sb_wr_left", exp_wr.size(), 32'd0);
        chk("sb_rd_left", exp_rd.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
